sm_als_reader: RTL and testbench

- SPI master that reads the 8-bit ambient-light value from the ADC081S021-type light sensor on the alsCS/alsSCK/alsSDO pins.
- Sits between those pins (driven in simulation by sm_als_stub) and the memory-mapped peripheral wrapper.
- The wrapper exposes start/auto control and the latched result to the CPU.
- Single-shot or free-running conversions, with a one-cycle valid strobe per result.

---
 rtl/sm_als_reader_pkg.sv | 20 ++
 rtl/sm_als_reader_if.sv | 24 ++
 rtl/sm_als_sck_gen.sv | 37 +++
 rtl/sm_als_reader.sv | 92 +++++++++
 tb/tb_sm_als_reader.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/sm_als_reader_pkg.sv
// Shared definitions for the ambient-light sensor reader: FSM states and
// frame layout of the ADC081S021-type 16-bit serial word.
package sm_als_reader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    DONE,
    QUIET
  } alsState_e;

  localparam int FRAME_BITS = 16;
  // Light value sits between 3 leading zeros and 5 trailing bits.
  localparam int DATA_MSB   = 12;
  localparam int DATA_LSB   = 5;
  localparam int DATA_W     = DATA_MSB - DATA_LSB + 1;

endpackage

// File: rtl/sm_als_reader_if.sv
// Control/result and sensor-pin bundle of the light-sensor reader.
// master = the reader itself, slave = wrapper plus sensor side.
interface sm_als_reader_if import sm_als_reader_pkg::*; ();

  logic              start;
  logic              auto;
  logic              busy;
  logic              valid;
  logic [DATA_W-1:0] data;
  logic              alsCS;
  logic              alsSCK;
  logic              alsSDO;

  modport master (
    input  start, auto, alsSDO,
    output busy, valid, data, alsCS, alsSCK
  );

  modport slave (
    output start, auto, alsSDO,
    input  busy, valid, data, alsCS, alsSCK
  );

endinterface

// File: rtl/sm_als_sck_gen.sv
// SCK generator: half-period timer plus SCK level register. tick marks the
// last cycle of a half-period; rise/fall flag the edge that moves SCK.
module sm_als_sck_gen #(
  parameter int SCK_HALF = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic toggleEn,
  output logic sck,
  output logic tick,
  output logic rise,
  output logic fall
);

  localparam logic [7:0] RELOAD = 8'(SCK_HALF - 1);

  logic [7:0] halfCnt;

  assign tick = run && (halfCnt == 8'd0);
  assign rise = tick && toggleEn && !sck;
  assign fall = tick && toggleEn && sck;

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halfCnt <= 8'd0;
      sck     <= 1'b1;
    end else begin
      // Held at reload while stopped so the first phase is a full half-period.
      if (!run || tick) halfCnt <= RELOAD;
      else              halfCnt <= halfCnt - 8'd1;
      if (tick && toggleEn) sck <= !sck;
    end
  end

endmodule

// File: rtl/sm_als_reader.sv
// SPI master reading one 16-bit frame from the light sensor and latching the
// 8-bit light value; single-shot on start, free-running while auto is high.
module sm_als_reader import sm_als_reader_pkg::*; #(
  parameter int SCK_HALF  = 4,
  parameter int QUIET_CYC = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  sm_als_reader_if.master bus
);

  alsState_e             stateQ, stateNext;
  logic                  run, toggleEn, sck, tick, rise, fall, lastBit;
  logic [4:0]            bitCnt;
  // Bit 15 of the frame would only ever hold the first leading zero, so it
  // is shifted out rather than stored.
  logic [FRAME_BITS-2:0] shReg;
  logic [7:0]            quietCnt;
  logic                  csNext, busyNext, validNext;

  assign run      = stateQ inside {SETUP, SHIFT, HOLD};
  assign lastBit  = (bitCnt == 5'(FRAME_BITS));
  // Stop toggling once the 16th high phase ends so SCK stays high into HOLD.
  assign toggleEn = (stateQ == SETUP) || (stateQ == SHIFT && !(sck && lastBit));

  sm_als_sck_gen #(.SCK_HALF(SCK_HALF)) u_sck_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .toggleEn (toggleEn),
    .sck      (sck),
    .tick     (tick),
    .rise     (rise),
    .fall     (fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stateQ <= IDLE;
    else        stateQ <= stateNext;
  end

  // NOTE: default first so no path through the case can infer a latch.
  always_comb begin
    stateNext = stateQ;
    case (stateQ)
      IDLE:    if (bus.start || bus.auto) stateNext = SETUP;
      SETUP:   if (fall) stateNext = SHIFT;
      SHIFT:   if (tick && sck && lastBit) stateNext = HOLD;
      HOLD:    if (tick) stateNext = DONE;
      DONE:    stateNext = (QUIET_CYC == 0) ? IDLE : QUIET;
      QUIET:   if (quietCnt == 8'd0) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered below.
  always_comb begin
    csNext    = !(stateNext inside {SETUP, SHIFT, HOLD});
    busyNext  = (stateNext != IDLE);
    validNext = (stateNext == DONE);
  end

  // NOTE: the shift register is reset too, so a frame aborted by reset never leaks into data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.alsCS <= 1'b1;
      bus.busy  <= 1'b0;
      bus.valid <= 1'b0;
      bus.data  <= '0;
      bitCnt    <= 5'd0;
      shReg     <= '0;
      quietCnt  <= 8'd0;
    end else begin
      bus.alsCS <= csNext;
      bus.busy  <= busyNext;
      bus.valid <= validNext;
      if (validNext) bus.data <= shReg[DATA_MSB:DATA_LSB];

      if (stateQ == IDLE) bitCnt <= 5'd0;
      else if (rise)      bitCnt <= bitCnt + 5'd1;

      // SCK is generated here, so alsSDO is stable at our own rising edge.
      if (rise) shReg <= {shReg[FRAME_BITS-3:0], bus.alsSDO};

      if (stateQ == DONE)       quietCnt <= 8'(QUIET_CYC - 1);
      else if (stateQ == QUIET) quietCnt <= quietCnt - 8'd1;
    end
  end

  assign bus.alsSCK = sck;

endmodule

// File: tb/tb_sm_als_reader.sv
// Bench for sm_als_reader: two instances (default timing and SCK_HALF=1 /
// QUIET_CYC=0) driven by a per-cycle sensor model with random frames.
module tb_sm_als_reader;

  localparam int H0 = 4;
  localparam int Q0 = 8;
  localparam int H1 = 1;
  localparam int Q1 = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rstN, startDrv, autoDrv, sdoDrv;
  logic [1:0] busyObs, validObs, csObs, sckObs;
  logic [7:0] dataObs [2];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : gDut
    sm_als_reader_if bus();
    assign bus.start   = startDrv[g];
    assign bus.auto    = autoDrv[g];
    assign bus.alsSDO  = sdoDrv[g];
    assign busyObs[g]  = bus.busy;
    assign validObs[g] = bus.valid;
    assign csObs[g]    = bus.alsCS;
    assign sckObs[g]   = bus.alsSCK;
    assign dataObs[g]  = bus.data;
    if (g == 0) begin : gDef
      sm_als_reader #(.SCK_HALF(H0), .QUIET_CYC(Q0)) dut (
        .clk(clk), .rst_n(rstN[g]), .bus(bus));
    end else begin : gFast
      sm_als_reader #(.SCK_HALF(H1), .QUIET_CYC(Q1)) dut (
        .clk(clk), .rst_n(rstN[g]), .bus(bus));
    end
  end

  int nChecks = 0;
  int nFails  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Event record filled by watch().
  int          validCyc[$];
  int          validData[$];
  int          busyFallCyc[$];
  int          fallsPerXfer[$];
  int          csRises;
  logic [15:0] frameQ[$];
  logic [15:0] curFrame;
  int          bitIdx, fallCnt;
  logic        csPrev, sckPrev, busyPrev;

  function automatic int getAt(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // Reference timing. Samples are taken at the falling edge after posedge
  // number cyc, so "cycle N" of the description is observed at cyc == N-1.
  // Conversion: SETUP h + 16 SCK periods 2h + HOLD h = 34h, then DONE.
  function automatic int expValidAt(input int e0, input int h);
    return e0 + 34 * h;
  endfunction
  // IDLE follows DONE (1 cycle) and QUIET (q cycles).
  function automatic int expIdleAt(input int e0, input int h, input int q);
    return expValidAt(e0, h) + 1 + q;
  endfunction

  task automatic clearRec();
    validCyc.delete(); validData.delete(); busyFallCyc.delete();
    fallsPerXfer.delete(); frameQ.delete();
    csRises = 0;
  endtask

  task automatic syncPrev(input int d);
    csPrev = csObs[d]; sckPrev = sckObs[d]; busyPrev = busyObs[d];
  endtask

  // Advance n cycles: play the sensor (next bit after each SCK fall) and log events.
  task automatic watch(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (csPrev && !csObs[d]) begin
        curFrame = (frameQ.size() > 0) ? frameQ.pop_front() : 16'h0000;
        bitIdx   = 15;
        fallCnt  = 0;
      end
      if (!csObs[d] && sckPrev && !sckObs[d]) begin
        sdoDrv[d] = (bitIdx >= 0) ? curFrame[bitIdx] : 1'b0;
        bitIdx--;
        fallCnt++;
      end
      if (!csPrev && csObs[d]) begin
        csRises++;
        fallsPerXfer.push_back(fallCnt);
      end
      if (validObs[d]) begin
        validCyc.push_back(cyc);
        validData.push_back(int'(dataObs[d]));
      end
      if (busyPrev && !busyObs[d]) busyFallCyc.push_back(cyc);
      syncPrev(d);
    end
  endtask

  task automatic pulseStart(input int d, output int e0);
    startDrv[d] = 1'b1;
    e0 = cyc + 1;
    watch(d, 1);
    startDrv[d] = 1'b0;
  endtask

  task automatic runFrame(input int d, input int h, input int q, input logic [15:0] frame,
                          input string tag);
    int          e0;
    logic [7:0]  expData;
    expData = frame[12:5];
    clearRec();
    syncPrev(d);
    frameQ.push_back(frame);
    pulseStart(d, e0);
    check({tag, ".busy_rise"}, busyObs[d], 1'b1);
    check({tag, ".cs_low"}, csObs[d], 1'b0);
    watch(d, 34 * h + q + 10);
    check({tag, ".valid_cnt"}, validCyc.size(), 1);
    check({tag, ".valid_at"}, getAt(validCyc, 0), expValidAt(e0, h));
    check({tag, ".data"}, getAt(validData, 0), expData);
    check({tag, ".busy_fall"}, getAt(busyFallCyc, 0), expIdleAt(e0, h, q));
    check({tag, ".sck_falls"}, getAt(fallsPerXfer, 0), 16);
    check({tag, ".cs_rises"}, csRises, 1);
    check({tag, ".data_held"}, dataObs[d], expData);
    check({tag, ".sck_idle"}, sckObs[d], 1'b1);
  endtask

  logic [15:0] fr;
  int          e0;
  int          v0;

  initial begin
    rstN = 2'b00; startDrv = 2'b00; autoDrv = 2'b00; sdoDrv = 2'b00;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst.cs", csObs[d], 1'b1);
      check("rst.sck", sckObs[d], 1'b1);
      check("rst.busy", busyObs[d], 1'b0);
      check("rst.valid", validObs[d], 1'b0);
      check("rst.data", dataObs[d], 8'h00);
    end
    rstN = 2'b11;
    repeat (2) @(negedge clk);

    runFrame(0, H0, Q0, {3'b000, 8'hA5, 5'b00000}, "a5");
    runFrame(0, H0, Q0, {3'b111, 8'h3C, 5'b11111}, "pad3c");
    for (int i = 0; i < 4; i++) begin
      fr = 16'($urandom);
      runFrame(0, H0, Q0, fr, "rnd");
      watch(0, $urandom_range(0, 5));
    end

    // start pulsed again while busy: ignored, not queued.
    clearRec(); syncPrev(0);
    frameQ.push_back({3'b000, 8'h5A, 5'b00000});
    pulseStart(0, e0);
    watch(0, 49);
    startDrv[0] = 1'b1;
    watch(0, 1);
    startDrv[0] = 1'b0;
    watch(0, 150);
    check("busy_start.valid_cnt", validCyc.size(), 1);
    check("busy_start.valid_at", getAt(validCyc, 0), expValidAt(e0, H0));
    check("busy_start.data", getAt(validData, 0), 8'h5A);
    check("busy_start.cs_rises", csRises, 1);

    // Free-running: restart on the IDLE cycle, auto dropped mid second frame.
    clearRec(); syncPrev(0);
    frameQ.push_back({3'b000, 8'h11, 5'b00000});
    frameQ.push_back({3'b000, 8'h22, 5'b00000});
    autoDrv[0] = 1'b1;
    e0 = cyc + 1;
    watch(0, 206);
    autoDrv[0] = 1'b0;
    watch(0, 250);
    v0 = expValidAt(e0, H0);
    check("auto.valid_cnt", validCyc.size(), 2);
    check("auto.valid0_at", getAt(validCyc, 0), v0);
    check("auto.valid1_at", getAt(validCyc, 1), expValidAt(expIdleAt(e0, H0, Q0) + 1, H0));
    check("auto.spacing", getAt(validCyc, 1) - getAt(validCyc, 0), 146);
    check("auto.data0", getAt(validData, 0), 8'h11);
    check("auto.data1", getAt(validData, 1), 8'h22);
    check("auto.cs_rises", csRises, 2);
    check("auto.busy_end", busyObs[0], 1'b0);

    // Reset in the middle of a transfer aborts it asynchronously.
    clearRec(); syncPrev(0);
    fr = 16'($urandom);
    frameQ.push_back(fr);
    pulseStart(0, e0);
    watch(0, 59);
    #2 rstN[0] = 1'b0;
    #1;
    check("midrst.cs", csObs[0], 1'b1);
    check("midrst.sck", sckObs[0], 1'b1);
    check("midrst.busy", busyObs[0], 1'b0);
    check("midrst.data", dataObs[0], 8'h00);
    @(negedge clk);
    rstN[0] = 1'b1;
    syncPrev(0);
    watch(0, 5);
    check("midrst.no_valid", validCyc.size(), 0);
    fr = 16'($urandom);
    runFrame(0, H0, Q0, fr, "post_rst");

    // Fastest timing, no quiet gap.
    fr = {3'($urandom), 8'hFF, 5'($urandom)};
    runFrame(1, H1, Q1, fr, "fast_ff");
    for (int i = 0; i < 2; i++) begin
      fr = 16'($urandom);
      runFrame(1, H1, Q1, fr, "fast_rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
